// File: rtl/gpu_pkg.sv
// Shared GPU display constants and the scanout state encoding.
// Framebuffer geometry defaults live here so every block agrees on them.
package gpu_pkg;

    localparam int H_PIXELS_C = 320;
    localparam int V_LINES_C  = 240;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int FB_AW      = 20;
    localparam int IDX_W      = 17;
    localparam int PIX_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO between the memory read port and the pixel output.
// Illegal pushes (full, no pop) and pops (empty) are silently ignored.
module pix_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: walks the frame in raster order, issues credit-limited
// pipelined reads and hands the returned words out tagged with (x,y).
module fb_scanout
    import gpu_pkg::*;
#(
    parameter int               H_PIXELS = H_PIXELS_C,
    parameter int               V_LINES  = V_LINES_C,
    parameter logic [FB_AW-1:0] FB_BASE  = 20'h00000,
    parameter int               DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             mem_req,
    output logic [FB_AW-1:0] mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_data,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y
);

    localparam int               CW       = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_PIXELS * V_LINES - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    w_count;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_frame_done;
    logic             w_done_nxt;
    logic             w_busy;
    logic             w_credit;
    logic             w_req;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    logic             w_start;

    // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_count}) < (CW+1)'(DEPTH);
    assign w_req    = (r_state == RUN) && w_credit;
    assign w_grant  = w_req && mem_gnt;
    assign w_push   = mem_rvalid && (r_inflight != '0);
    assign w_pop    = pix_valid && pix_ready;
    assign w_start  = (r_state == IDLE) && start;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_grant && (r_idx == LAST_IDX)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if ((r_inflight == '0) &&
                    ((w_count == '0) || (w_pop && (w_count == CW'(1))))) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx      <= '0;
            r_inflight <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else if (w_start) begin
            r_idx      <= '0;
            r_inflight <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            if (w_grant) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // A stray return with nothing in flight is dropped, so the count never underflows.
            if (w_grant && !w_push) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_grant && w_push) begin
                r_inflight <= r_inflight - CW'(1);
            end
            if (w_pop) begin
                if (r_x == X_W'(H_PIXELS - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_W'(V_LINES - 1)) ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
        end
    end

    pix_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PIX_W)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_push  (w_push),
        .i_wdata (mem_rdata),
        .i_pop   (w_pop),
        .o_rdata (pix_data),
        .o_count (w_count)
    );

    assign pix_valid  = (w_count != '0);
    assign mem_req    = w_req;
    assign mem_addr   = FB_BASE + FB_AW'(r_idx);
    assign busy       = w_busy;
    assign frame_done = r_frame_done;
    assign pix_x      = r_x;
    assign pix_y      = r_y;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a memory responder with random latency and a raster
// reference model (pixel k sits at (k mod 320, k div 320) with word base+k).
module tb_fb_scanout;

    localparam logic [19:0] TB_BASE = 20'h01230;
    localparam int          NPIX    = 320 * 240;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_grant, n_pix, n_done, done_pix;
    int gnt_pct, rdy_pct, lat_min, lat_max, last_due;
    bit stray;
    logic [15:0] pend_data [$];
    int          pend_due  [$];

    fb_scanout #(
        .H_PIXELS (320),
        .V_LINES  (240),
        .FB_BASE  (TB_BASE),
        .DEPTH    (4)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_addr(input int k);
        return TB_BASE + 20'(k);
    endfunction

    // One clock: drive inputs, sample pre-edge outputs, update the model, cross the edge.
    task automatic step();
        int   lat;
        int   due;
        logic g;
        logic h;
        mem_gnt    = (int'($urandom_range(99)) < gnt_pct);
        pix_ready  = (int'($urandom_range(99)) < rdy_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hBEEF;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data.pop_front();
            void'(pend_due.pop_front());
        end
        g = mem_req && mem_gnt;
        h = pix_valid && pix_ready;
        chk("outstanding_le_depth", 32'((n_grant - n_pix) <= 4), 32'd1);
        if (frame_done) begin
            n_done++;
            done_pix = n_pix;
        end
        if (g) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr(n_grant)));
            lat = lat_min + int'($urandom_range(lat_max - lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_data.push_back(mem_addr[15:0]);
            pend_due.push_back(due);
            n_grant++;
        end
        if (h) begin
            chk("pix_data", 32'(pix_data), 32'(exp_addr(n_pix) & 20'hFFFF));
            chk("pix_x", 32'(pix_x), 32'(n_pix % 320));
            chk("pix_y", 32'(pix_y), 32'((n_pix / 320) % 240));
            n_pix++;
        end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic reset_model();
        n_grant  = 0;
        n_pix    = 0;
        n_done   = 0;
        done_pix = -1;
        pend_data.delete();
        pend_due.delete();
        last_due = cyc;
    endtask

    initial begin
        Reset_n    = 1'b0;
        start      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        pix_ready  = 1'b0;
        stray      = 1'b0;
        gnt_pct    = 100;
        rdy_pct    = 100;
        lat_min    = 2;
        lat_max    = 2;
        reset_model();

        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'(TB_BASE));
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Stray read return while idle must not produce a pixel.
        repeat (2) step();
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("stray_pix_valid", 32'(pix_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        step();
        chk("stray_pix_valid_later", 32'(pix_valid), 32'd0);

        // Full frame, free-running memory, latency 2, start pulsed mid-frame.
        reset_model();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_mem_req", 32'(mem_req), 32'd1);
        chk("start_mem_addr", 32'(mem_addr), 32'(TB_BASE));
        for (int i = 0; i < 78000 && n_done == 0; i++) begin
            start = (i == 100 || i == 40000);
            step();
        end
        start = 1'b0;
        repeat (5) step();
        chk("frame_done_pulses", 32'(n_done), 32'd1);
        chk("frame_done_after_last_pixel", 32'(done_pix), 32'(NPIX));
        chk("frame_pixels", 32'(n_pix), 32'(NPIX));
        chk("frame_grants", 32'(n_grant), 32'(NPIX));
        chk("frame_busy_after", 32'(busy), 32'd0);

        // Display stalled: requests must stop once four words are owed.
        reset_model();
        rdy_pct = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        chk("stall_grants", 32'(n_grant), 32'd4);
        chk("stall_mem_req", 32'(mem_req), 32'd0);
        chk("stall_pix_valid", 32'(pix_valid), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);

        // Release, then randomized grant/ready and latency 1..5 up to pixel 1000.
        gnt_pct = 50;
        rdy_pct = 50;
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 20000 && n_pix < 1000; i++) step();
        chk("mid_pix_count", 32'(n_pix), 32'd1000);

        // Asynchronous reset in the middle of the frame.
        #2;
        Reset_n    = 1'b0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'(TB_BASE));
        chk("arst_pix_valid", 32'(pix_valid), 32'd0);
        chk("arst_pix_data", 32'(pix_data), 32'd0);
        chk("arst_pix_x", 32'(pix_x), 32'd0);
        chk("arst_pix_y", 32'(pix_y), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // New frame after reset restarts at (0,0) / FB_BASE.
        reset_model();
        gnt_pct = 100;
        rdy_pct = 100;
        lat_min = 1;
        lat_max = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_mem_req", 32'(mem_req), 32'd1);
        chk("restart_mem_addr", 32'(mem_addr), 32'(TB_BASE));
        repeat (40) step();
        chk("restart_pix_count", 32'(n_pix), 32'd38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer scanout reader for the GPU. The drawing side writes pixels by (x,y) coordinate, with x wrapping at 320 and carrying into y, which wraps at 240. This block reads those pixels back. On `start` it walks the 320x240 framebuffer in raster order, issues pipelined memory read requests, buffers the returned words in a small FIFO, and presents them to the display side with a valid/ready handshake, tagged with their (x,y) coordinate.

## Interface
Parameters:
- `H_PIXELS`, default 320: pixels per line. x wraps to 0 here and carries into y.
- `V_LINES`, default 240: lines per frame. y wraps to 0 here.
- `FB_BASE`, default 20'h00000: word address of pixel (0,0).
- `DEPTH`, default 4: FIFO depth, which is also the maximum number of reads in flight plus buffered words. Must be a power of 2, at least 2.

Ports:
- `Clk`, in, 1: single clock. All logic is on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: pulse to begin a frame. Sampled only in IDLE.
- `busy`, out, 1: high in RUN and DRAIN.
- `frame_done`, out, 1: one-cycle pulse when the last pixel has been handed off.
- `mem_req`, out, 1: read request. Held with a stable `mem_addr` until granted.
- `mem_addr`, out, 20: read word address, equal to FB_BASE + y*H_PIXELS + x.
- `mem_gnt`, in, 1: request accepted in any cycle where `mem_req && mem_gnt`.
- `mem_rvalid`, in, 1: read data valid. Exactly one per granted request, returned in order, latency of 1 or more cycles.
- `mem_rdata`, in, 16: read data.
- `pix_valid`, out, 1: pixel available.
- `pix_ready`, in, 1: a pixel transfers in any cycle where `pix_valid && pix_ready`.
- `pix_data`, out, 16: pixel word.
- `pix_x`, out, 9: x coordinate of `pix_data`.
- `pix_y`, out, 8: y coordinate of `pix_data`.

## Operation
- The state machine is `scan_state_t`, with states IDLE, RUN and DRAIN.
- IDLE to RUN: on `start`. Clears the request index, the output x/y, and the in-flight count. `start` is ignored in RUN and DRAIN.
- RUN: `mem_req` = credit, where credit = (inflight + fifo_count < DEPTH). Both terms are register values, so a FIFO pop only frees credit from the next cycle.
- On each grant, the request index increments.
- RUN to DRAIN: when the grant for index H_PIXELS*V_LINES-1 occurs. `mem_req` drops in that same grant cycle's next state, so at most one request per address is ever issued.
- DRAIN to IDLE: once inflight==0 and the FIFO is empty after the final pixel handshake. `frame_done` pulses for one cycle on entering IDLE.
- In-flight count: +1 on grant, -1 on `mem_rvalid`. Both in the same cycle leave it unchanged.
- A `mem_rvalid` while inflight==0 is a protocol error. The data is dropped and the count saturates at 0.
- On each `mem_rvalid`, `mem_rdata` is pushed. The credit rule guarantees the FIFO never overflows.
- `pix_valid` = FIFO not empty. `pix_data` is the FIFO head (first-word-fall-through).
- Output coordinates advance on each pixel handshake: x+1. When x+1 == H_PIXELS, x becomes 0 and y becomes y+1. When y+1 == V_LINES as well, y becomes 0.
- Address arithmetic: linear index, 17 bits unsigned. `mem_addr` = FB_BASE + index, computed at 20 bits with modulo-2^20 wrap.

## Timing
Reset values: `mem_req`=0, `mem_addr`=FB_BASE, `pix_valid`=0, `pix_data`=0, `pix_x`=0, `pix_y`=0, `busy`=0, `frame_done`=0. State is IDLE and the FIFO is empty.
- `start` seen high at edge t: `busy` and `mem_req` are high after edge t, with `mem_addr`=FB_BASE.
- Back-to-back grants are allowed, one per cycle, up to DEPTH requests.
- `mem_rvalid` at edge t: `pix_valid` is high after edge t. The minimum read-to-pixel latency is 1 cycle.
- Simultaneous FIFO push and pop are allowed at any occupancy, including full with a pop.
- `pix_ready` may be held low indefinitely. Requests stall once credit runs out. No data is lost.
- `Reset_n` low in any state: immediate return to reset values. `mem_req` drops asynchronously.
- Reads in flight at reset are the memory system's responsibility.

## Structure
- `gpu_pkg` holds `H_PIXELS_C`=320, `V_LINES_C`=240, `X_W`=9, `Y_W`=8, `FB_AW`=20, and the `scan_state_t` enum. Parameter defaults are taken from it.
- Sub-module `pix_fifo`: a synchronous FIFO, DEPTH x 16, first-word-fall-through, with a `count` output, asynchronous active-low reset, and no overflow or underflow protection beyond ignoring the illegal operation.
- Top-level contents: the FSM, the request index, the in-flight counter, and the x/y wrap logic.

## Test plan
- Free-running memory (gnt=1, rvalid latency 2) with `pix_ready`=1. Required: 76800 pixels with `pix_data`==address and coordinates from (0,0) to (319,239), (319,0) followed by (0,1), exactly one `frame_done`, and `busy` low afterwards.
- `pix_ready`=0 for 50 cycles after start. Required: exactly 4 grants, then `mem_req`=0. With `pix_ready` released, pixels 0..3 appear in order.
- Random `mem_gnt`/`pix_ready` at 50%, latency 1 to 5. Required: a scoreboard match on every pixel, and inflight+count never above 4.
- `start` pulsed during RUN. Required: no effect, and the frame completes normally.
- `Reset_n` asserted mid-frame at pixel 1000. Required: all outputs at reset values the same cycle. A new start begins again at (0,0) with address FB_BASE.
- Stray `mem_rvalid` in IDLE. Required: `pix_valid` stays 0.
